// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad dimensions, scan FSM states and key code helpers
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  // Candidate and stable codes carry an extra MSB so "no key" never aliases a real code.
  localparam logic [KEY_W:0] KEY_NONE = {1'b1, {KEY_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} scan_state_e;

  function automatic logic [KEY_W-1:0] pack_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic [1:0] code_row(input logic [KEY_W-1:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] code_col(input logic [KEY_W-1:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - synchronous key event queue; push and pop together are both honoured even when full
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// rtl/keypad_scan_sequencer.sv - 4x4 keypad column scanner with frame debounce and event queue
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan_sequencer
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 8,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  output logic [1:0]       col_idx,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DEB_W    = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]          rows_meta_q, rows_meta_d, rows_sync_q, rows_sync_d;
  scan_state_e         state_q, state_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [3:0]          cols_q, cols_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [11:0]         frame_q, frame_d;
  logic [KEY_W:0]      cand_q, cand_d, stable_q, stable_d, cand;
  logic [DEB_W-1:0]    deb_q, deb_d, deb_n;
  logic                key_down_q, key_down_d, overflow_q, overflow_d;
  logic [15:0]         frame_all;
  logic [4:0]          hits;
  logic [KEY_W-1:0]    hit_code, fifo_data;
  logic                eval, ghost, stable_chg, press_push, rep_push, push, pop;
  logic                fifo_full, fifo_empty;

  always_comb begin
    rows_meta_d = rows;
    rows_sync_d = rows_meta_q;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cols_d      = cols_q;
    settle_d    = settle_q;
    frame_d     = frame_q;
    eval        = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      col_idx_d = '0;
      cols_d    = '0;
      settle_d  = '0;
      frame_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = DRIVE;
          col_idx_d = '0;
          cols_d    = 4'b0001;
          settle_d  = '0;
        end
        DRIVE: begin
          if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
          else settle_d = settle_q + 1'b1;
        end
        SAMPLE: begin
          for (int c = 0; c < NUM_COLS - 1; c++) begin
            if (col_idx_q == 2'(c)) frame_d[c*4 +: 4] = rows_sync_q;
          end
          eval      = (col_idx_q == 2'd3);
          col_idx_d = col_idx_q + 2'd1;
          cols_d    = 4'b0001 << col_idx_d;
          settle_d  = '0;
          state_d   = DRIVE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Column 3 is judged straight from the synchroniser rather than waiting a cycle to latch it.
    frame_all = {rows_sync_q, frame_q};
    hits      = '0;
    hit_code  = '0;
    for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
      if (frame_all[i]) begin
        hits     = hits + 5'd1;
        hit_code = pack_code(2'(i), 2'(i >> 2));
      end
    end
    ghost = eval && (hits > 5'd1);
    cand  = (hits == 5'd0) ? KEY_NONE : {1'b0, hit_code};
    if (deb_q != '0 && cand == cand_q)
      deb_n = (deb_q == DEB_W'(DEBOUNCE_FRAMES)) ? deb_q : deb_q + 1'b1;
    else
      deb_n = DEB_W'(1);
    stable_chg = eval && !ghost && (deb_n == DEB_W'(DEBOUNCE_FRAMES)) && (cand != stable_q);
    press_push = stable_chg && !cand[KEY_W];

    cand_d     = cand_q;
    deb_d      = deb_q;
    stable_d   = stable_q;
    key_down_d = key_down_q;
    if (!enable) begin
      cand_d = KEY_NONE;
      deb_d  = '0;
    end else if (ghost) begin
      deb_d = '0;
    end else if (eval) begin
      cand_d = cand;
      deb_d  = deb_n;
      if (stable_chg) begin
        stable_d   = cand;
        key_down_d = !cand[KEY_W];
      end
    end

    push       = press_push || rep_push;
    pop        = key_valid && key_ready;
    overflow_d = (push && fifo_full && !pop) || (overflow_q && !ovf_clr);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
  logic             rep_armed_q, rep_armed_d;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_push    = 1'b0;
    rep_limit   = rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
    if (!enable || ghost || stable_chg) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (eval && !stable_q[KEY_W] && cand == stable_q) begin
      if (rep_cnt_q + 1'b1 == rep_limit) begin
        rep_push    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  // Repeat timing parameters are inert in this build.
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DELAY + REPEAT_RATE);
  assign rep_push          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= '0;
      rows_sync_q <= '0;
      state_q     <= IDLE;
      col_idx_q   <= '0;
      cols_q      <= '0;
      settle_q    <= '0;
      frame_q     <= '0;
      cand_q      <= KEY_NONE;
      deb_q       <= '0;
      stable_q    <= KEY_NONE;
      key_down_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rows_meta_q <= rows_meta_d;
      rows_sync_q <= rows_sync_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cols_q      <= cols_d;
      settle_q    <= settle_d;
      frame_q     <= frame_d;
      cand_q      <= cand_d;
      deb_q       <= deb_d;
      stable_q    <= stable_d;
      key_down_q  <= key_down_d;
      overflow_q  <= overflow_d;
    end
  end

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (stable_d[KEY_W-1:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cols      = cols_q;
  assign col_idx   = col_idx_q;
  assign key_code  = fifo_data;
  assign key_valid = !fifo_empty;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb/tb_keypad_scan_sequencer.sv - directed bench for keypad_scan_sequencer (12-cycle frames)
// Build with KEYPAD_REPEAT_EN defined to also exercise the repeat schedule.
module tb_keypad_scan_sequencer;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, key_ready, ovf_clr;
  logic [3:0]  rows, cols;
  logic [1:0]  col_idx;
  logic [3:0]  key_code;
  logic        key_valid, key_down, overflow;
  logic [15:0] mask;
  int          checks = 0;
  int          failures = 0;

  keypad_scan_sequencer #(
    .SETTLE_CYCLES   (2),
    .DEBOUNCE_FRAMES (3),
    .FIFO_DEPTH      (4),
    .REPEAT_DELAY    (4),
    .REPEAT_RATE     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rows      (rows),
    .cols      (cols),
    .col_idx   (col_idx),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad model: mask bit col*4+row closes the switch between that column and row.
  always_comb begin
    rows = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (cols[c] && mask[c*4+r]) rows[r] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic restart_scan();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  int         press_bits [5] = '{0, 5, 10, 15, 7};
  logic [3:0] exp_codes  [4] = '{4'h0, 4'h5, 4'hA, 4'hF};
`ifdef KEYPAD_REPEAT_EN
  localparam int N_EVT = 5;
  int exp_evt [N_EVT] = '{36, 84, 108, 132, 156};
`else
  localparam int N_EVT = 1;
  int exp_evt [N_EVT] = '{36};
`endif
  int   evt_cyc  [8];
  logic [3:0] evt_code [8];
  int   n_evt;
  logic found;

  initial begin
    reset = 1'b1; enable = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0; mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_cols", 32'(cols), 32'h0);
    check("rst_col_idx", 32'(col_idx), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    // Reset asserted while column 2 is being sampled.
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == SAMPLE && col_idx == 2'd2) found = 1'b1;
    end
    check("mid_found", 32'(found), 32'h1);
    check("mid_cols_before", 32'(cols), 32'h4);
    reset = 1'b1;
    #1;
    check("mid_cols", 32'(cols), 32'h0);
    check("mid_valid", 32'(key_valid), 32'h0);
    check("mid_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk); reset = 1'b0;

    // Row 1 held under column 2: accepted on the third frame only.
    mask = 16'h0200;
    restart_scan();
    wait_cycles(24);
    check("press_early_valid", 32'(key_valid), 32'h0);
    check("press_early_down", 32'(key_down), 32'h0);
    wait_cycles(12);
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_code", 32'(key_code), 32'h6);
    check("press_down", 32'(key_down), 32'h1);
    pop_one();
    check("press_popped", 32'(key_valid), 32'h0);
    wait_cycles(24);
    check("press_single_evt", 32'(key_valid), 32'h0);

    // Release: key_down drops after three empty frames, nothing queued.
    mask = '0;
    restart_scan();
    wait_cycles(24);
    check("rel_early_down", 32'(key_down), 32'h1);
    wait_cycles(12);
    check("rel_down", 32'(key_down), 32'h0);
    check("rel_valid", 32'(key_valid), 32'h0);

    // Bounce two frames on, one off, twice.
    mask = 16'h0008;
    restart_scan();
    wait_cycles(24); mask = '0;
    wait_cycles(12); mask = 16'h0008;
    wait_cycles(24); mask = '0;
    wait_cycles(12);
    check("bounce_valid", 32'(key_valid), 32'h0);
    check("bounce_down", 32'(key_down), 32'h0);

    // Ghost: two rows at column 1 while a key is stably down.
    mask = 16'h0020;
    restart_scan();
    wait_cycles(36);
    check("pre_ghost_code", 32'(key_code), 32'h5);
    pop_one();
    mask = 16'h0050;
    restart_scan();
    wait_cycles(48);
    check("ghost_valid", 32'(key_valid), 32'h0);
    check("ghost_down", 32'(key_down), 32'h1);
    mask = '0;
    restart_scan();
    wait_cycles(36);
    check("ghost_release_down", 32'(key_down), 32'h0);

    // Five key-to-key presses with no consumer: fifth is dropped.
    restart_scan();
    for (int i = 0; i < 5; i++) begin
      mask = 16'(1) << press_bits[i];
      wait_cycles(36);
      if (i == 3) check("ovf_before", 32'(overflow), 32'h0);
    end
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_head_held", 32'(key_code), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_valid%0d", i), 32'(key_valid), 32'h1);
      check($sformatf("ovf_code%0d", i), 32'(key_code), 32'(exp_codes[i]));
      pop_one();
    end
    mask = '0;
    check("ovf_drained", 32'(key_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);
    restart_scan();
    wait_cycles(36);
    check("ovf_release_down", 32'(key_down), 32'h0);

    // Long hold with an always-ready consumer: event timing relative to scan start.
    mask      = 16'h0200;
    key_ready = 1'b1;
    n_evt     = 0;
    restart_scan();
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk); @(negedge clk);
      if (key_valid && n_evt < 8) begin
        evt_cyc[n_evt]  = c;
        evt_code[n_evt] = key_code;
        n_evt++;
      end
    end
    key_ready = 1'b0;
    mask      = '0;
    check("hold_evt_count", 32'(n_evt), 32'(N_EVT));
    for (int i = 0; i < N_EVT; i++) begin
      if (i < n_evt) begin
        check($sformatf("hold_evt_cyc%0d", i), 32'(evt_cyc[i]), 32'(exp_evt[i]));
        check($sformatf("hold_evt_code%0d", i), 32'(evt_code[i]), 32'h6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
